rf_param: RTL and testbench
===========================

# rf_param

Parametrised multi-port register file with write-to-read bypass, an optional hard-wired zero register and a per-entry pending scoreboard. It replaces the fixed 32x64, 2-read/1-write register file in the core datapath. Decode reserves destination registers and writeback releases them. Read ports report both data and whether that data is still awaited.

## Interface
- DATA_W, 64, register width in bits
- NUM_REGS, 32, number of entries (power of two, ≥2)
- ADDR_W, $clog2(NUM_REGS), address width
- NUM_RD, 2, read ports (1–4)
- NUM_WR, 1, write ports (1–2)
- ZERO_REG, 1, if 1 entry 0 always reads 0 and ignores writes and reserves
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all entries and pending bits
- rd_addr  input  NUM_RD*ADDR_W  read addresses, port i at [i*ADDR_W +: ADDR_W]
- rd_data  output  NUM_RD*DATA_W  read data
- rd_pending  output  NUM_RD  1 = addressed entry reserved, data stale
- wr_en  input  NUM_WR  write enables
- wr_addr  input  NUM_WR*ADDR_W  write addresses
- wr_data  input  NUM_WR*DATA_W  write data
- rsv_en  input  1  reserve request (decode issue)
- rsv_addr  input  ADDR_W  entry to mark pending
- rsv_ok  output  1  1 = reservation accepted this cycle

## Operation
- Storage: NUM_REGS x DATA_W flops plus NUM_REGS pending bits.
- Read: combinational. rd_data[i] = entry[rd_addr[i]], except:
  - ZERO_REG=1 and rd_addr[i]=0 -> 0;
  - bypass: if any wr_en[j] with wr_addr[j]=rd_addr[i] this cycle -> wr_data of the highest such j.
- rd_pending[i] = pending[rd_addr[i]] after write clearing in the same cycle: a write to the entry this cycle forces rd_pending=0 (bypassed data is valid). Reserve in the same cycle does not affect rd_pending until the next cycle.
- Write: on edge with wr_en[j], entry[wr_addr[j]] <= wr_data[j] and pending cleared. Two ports, same address: port 1 wins.
- Reserve: rsv_ok = rsv_en & ~(ZERO_REG & rsv_addr==0) & ~pending[rsv_addr]. If rsv_ok, pending[rsv_addr] <= 1 on edge. Reserve to an already-pending entry is refused (rsv_ok=0, no change); the decoder stalls.
- Write and accepted reserve to the same entry in the same cycle: data written, pending ends 1 (the new producer owns it).
- Writes/reserves to entry 0 with ZERO_REG=1: discarded; pending[0] constant 0.

## Timing
- Reset: on the edge with reset=1, all entries <= 0 and all pending <= 0. Reset overrides any same-cycle write or reserve. From the next cycle, rd_data=0 and rd_pending=0 on all ports, absent bypass.
- rsv_ok is combinational and does not itself depend on reset.
- Write latency: 0 cycles through bypass, 1 cycle via array.
- Reserve latency: pending visible on rd_pending the cycle after the accepting edge.
- No X on outputs after first reset edge, for any address in range.

## Structure
- Package rf_pkg: default DATA_W/NUM_REGS/NUM_RD/NUM_WR constants, and a typedef for the register address.
- Sub-module rf_scoreboard: pending bit vector, reserve accept logic, write-clear, reset. rf_param instantiates it alongside the data array and bypass muxes.

## Test plan
- Reset then read all 32 entries on both ports -> every rd_data=0, rd_pending=0.
- Write entry k with k*10, k=0..31, one per cycle, then read pairs (k, k+1) -> entry 0 reads 0 (ZERO_REG=1), others k*10.
- Same cycle: wr_en, wr_addr=5, wr_data=0xABCD, rd_addr[0]=5 -> rd_data[0]=0xABCD combinationally. With NUM_WR=2 and both ports writing 5 (0x11 port 0, 0x22 port 1), the next-cycle read gives 0x22.
- Reserve 7 -> rsv_ok=1; next cycle rd_pending=1 for addr 7; reserve 7 again -> rsv_ok=0. Write 7=0x55 -> same-cycle rd_pending=0, data 0x55; next cycle pending 0.
- Reserve 0 -> rsv_ok=0. Simultaneous write and reserve to 9 -> data updated, pending[9]=1 next cycle.
- Reset asserted in the same cycle as a write to 3 and a reserve of 4 -> next cycle entry 3=0, pending[4]=0.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared defaults and types for the parametrised register file.
package rf_pkg;

    localparam int DEFAULT_DATA_W   = 64;
    localparam int DEFAULT_NUM_REGS = 32;
    localparam int DEFAULT_NUM_RD   = 2;
    localparam int DEFAULT_NUM_WR   = 1;
    localparam int DEFAULT_ADDR_W   = $clog2(DEFAULT_NUM_REGS);

    // Register index type for the default-sized file.
    typedef logic [DEFAULT_ADDR_W-1:0] rf_addr_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending scoreboard: one bit per entry, set by an accepted reservation
// from decode and cleared by any writeback to that entry.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int NUM_WR   = DEFAULT_NUM_WR,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic                     rsv_ok,
    output logic [NUM_REGS-1:0]      pending
);

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;
    logic                rsv_to_zero;

    // A reservation is refused for the hard-wired zero entry and for any
    // entry that already has an outstanding producer (decode must stall).
    always_comb begin
        rsv_to_zero = (ZERO_REG != 0) && (rsv_addr == '0);
        rsv_ok      = rsv_en && !rsv_to_zero && !pending_q[rsv_addr];
    end

    // Writes clear pending first; a same-cycle accepted reserve then sets it
    // again because the newly issued producer owns the entry.
    always_comb begin
        pending_d = pending_q;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en[j]) begin
                pending_d[wr_addr[j*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        if (rsv_ok) begin
            pending_d[rsv_addr] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            pending_d[0] = 1'b0;
        end
    end

    // Pending register with synchronous reset overriding any update.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;

endmodule

// File: rtl/rf_param.sv
// Parametrised multi-port register file with write-to-read bypass,
// optional hard-wired zero entry and a pending scoreboard.
module rf_param
    import rf_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int NUM_RD   = DEFAULT_NUM_RD,
    parameter int NUM_WR   = DEFAULT_NUM_WR,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_pending,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic                     rsv_ok
);

    logic [DATA_W-1:0]   mem_q [NUM_REGS];
    logic [DATA_W-1:0]   mem_d [NUM_REGS];
    logic [NUM_REGS-1:0] pending;
    logic [NUM_RD-1:0]   rd_hit;

    rf_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .NUM_WR   (NUM_WR),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .rsv_ok   (rsv_ok),
        .pending  (pending)
    );

    // Next array contents: ports applied in ascending order so the highest
    // port wins on an address collision; entry 0 ignores writes when wired.
    always_comb begin
        mem_d = mem_q;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en[j] &&
                !((ZERO_REG != 0) && (wr_addr[j*ADDR_W +: ADDR_W] == '0))) begin
                mem_d[wr_addr[j*ADDR_W +: ADDR_W]] = wr_data[j*DATA_W +: DATA_W];
            end
        end
    end

    // Data array with synchronous clear on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                mem_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_REGS; k++) begin
                mem_q[k] <= mem_d[k];
            end
        end
    end

    // Read ports: array value, overridden by the highest matching write
    // port, then forced to zero for the wired entry; a bypass hit means the
    // data is fresh so pending is masked off.
    always_comb begin
        rd_data    = '0;
        rd_pending = '0;
        rd_hit     = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            rd_data[i*DATA_W +: DATA_W] = mem_q[rd_addr[i*ADDR_W +: ADDR_W]];
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] &&
                    (wr_addr[j*ADDR_W +: ADDR_W] == rd_addr[i*ADDR_W +: ADDR_W])) begin
                    rd_data[i*DATA_W +: DATA_W] = wr_data[j*DATA_W +: DATA_W];
                    rd_hit[i] = 1'b1;
                end
            end
            if ((ZERO_REG != 0) && (rd_addr[i*ADDR_W +: ADDR_W] == '0)) begin
                rd_data[i*DATA_W +: DATA_W] = '0;
            end
            rd_pending[i] = pending[rd_addr[i*ADDR_W +: ADDR_W]] && !rd_hit[i];
        end
    end

endmodule

// File: tb/tb_rf_param.sv
// Randomised and directed bench for rf_param (two write ports, zero entry).
module tb_rf_param;
   import rf_pkg::*;

   localparam int DW = DEFAULT_DATA_W;
   localparam int NR = DEFAULT_NUM_REGS;
   localparam int AW = DEFAULT_ADDR_W;

   logic            clk = 1'b0;
   logic            reset;
   logic [2*AW-1:0] rd_addr;
   logic [2*DW-1:0] rd_data;
   logic [1:0]      rd_pending;
   logic [1:0]      wr_en;
   logic [2*AW-1:0] wr_addr;
   logic [2*DW-1:0] wr_data;
   logic            rsv_en;
   logic [AW-1:0]   rsv_addr;
   logic            rsv_ok;

   int numCompared   = 0;
   int numMismatched = 0;

   logic [DW-1:0] refMem [NR];
   bit            refPend [NR];

   rf_param #(
      .DATA_W   (DW),
      .NUM_REGS (NR),
      .NUM_RD   (2),
      .NUM_WR   (2),
      .ZERO_REG (1)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .rd_pending (rd_pending),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .rsv_en     (rsv_en),
      .rsv_addr   (rsv_addr),
      .rsv_ok     (rsv_ok)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      numCompared++;
      if (obs !== exp) begin
         numMismatched++;
         $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Drives one cycle of inputs, checks the combinational outputs against
   // the reference model, then advances the model across the clock edge.
   task automatic applyStimulus(input bit rst, input bit [1:0] wen,
                                input int wa0, input logic [DW-1:0] wd0,
                                input int wa1, input logic [DW-1:0] wd1,
                                input bit rsven, input int ra,
                                input int r0, input int r1);
      int            raddr [2];
      logic [DW-1:0] expD;
      bit            hit;
      bit            expOk;
      @(negedge clk);
      reset    = rst;
      wr_en    = wen;
      wr_addr  = {AW'(wa1), AW'(wa0)};
      wr_data  = {wd1, wd0};
      rsv_en   = rsven;
      rsv_addr = AW'(ra);
      rd_addr  = {AW'(r1), AW'(r0)};
      raddr[0] = r0;
      raddr[1] = r1;
      #1;
      for (int p = 0; p < 2; p++) begin
         hit  = 1'b0;
         expD = refMem[raddr[p]];
         if (wen[0] && wa0 == raddr[p]) begin
            expD = wd0;
            hit  = 1'b1;
         end
         if (wen[1] && wa1 == raddr[p]) begin
            expD = wd1;
            hit  = 1'b1;
         end
         if (raddr[p] == 0) expD = '0;
         checkOutput($sformatf("rd_data%0d[%0d]", p, raddr[p]), rd_data[p*DW +: DW], expD);
         checkOutput($sformatf("rd_pending%0d[%0d]", p, raddr[p]), DW'(rd_pending[p]),
                     DW'(refPend[raddr[p]] && !hit));
      end
      expOk = rsven && (ra != 0) && !refPend[ra];
      checkOutput($sformatf("rsv_ok[%0d]", ra), DW'(rsv_ok), DW'(expOk));
      @(posedge clk);
      if (rst) begin
         for (int k = 0; k < NR; k++) begin
            refMem[k]  = '0;
            refPend[k] = 1'b0;
         end
      end else begin
         if (wen[0] && wa0 != 0) begin
            refMem[wa0]  = wd0;
            refPend[wa0] = 1'b0;
         end
         if (wen[1] && wa1 != 0) begin
            refMem[wa1]  = wd1;
            refPend[wa1] = 1'b0;
         end
         if (expOk) refPend[ra] = 1'b1;
      end
   endtask

   // Directed scenarios followed by a randomised soak.
   initial begin
      for (int k = 0; k < NR; k++) begin
         refMem[k]  = '0;
         refPend[k] = 1'b0;
      end
      reset    = 1'b1;
      wr_en    = '0;
      wr_addr  = '0;
      wr_data  = '0;
      rsv_en   = 1'b0;
      rsv_addr = '0;
      rd_addr  = '0;
      repeat (2) @(posedge clk);

      $display("[TB] reset read-back of all entries");
      for (int k = 0; k < NR; k++) applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, k, NR-1-k);

      $display("[TB] fill entries with k*10");
      for (int k = 0; k < NR; k++) applyStimulus(0, 2'b01, k, DW'(k*10), 0, 0, 0, 0, k, 0);
      for (int k = 0; k < NR-1; k++) applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, k, k+1);

      $display("[TB] bypass and dual-port write collision");
      applyStimulus(0, 2'b01, 5, 64'hABCD, 0, 0, 0, 0, 5, 4);
      applyStimulus(0, 2'b11, 5, 64'h11, 5, 64'h22, 0, 0, 5, 6);
      applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 5, 5);
      #2;
      checkOutput("collision_port1_wins", rd_data[DW-1:0], 64'h22);

      $display("[TB] reserve / refuse / writeback on entry 7");
      applyStimulus(0, 2'b00, 0, 0, 0, 0, 1, 7, 7, 8);
      applyStimulus(0, 2'b00, 0, 0, 0, 0, 1, 7, 7, 8);
      #2;
      checkOutput("pending7_held", DW'(rd_pending[0]), 64'd1);
      applyStimulus(0, 2'b01, 7, 64'h55, 0, 0, 0, 0, 7, 8);
      applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 7, 7);

      $display("[TB] zero-entry reserve and write+reserve on entry 9");
      applyStimulus(0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 9);
      applyStimulus(0, 2'b01, 9, 64'h99, 0, 0, 1, 9, 9, 0);
      applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 9, 0);

      $display("[TB] reset overrides write and reserve");
      applyStimulus(0, 2'b01, 3, 64'h33, 0, 0, 0, 0, 3, 3);
      applyStimulus(1, 2'b01, 3, 64'h77, 0, 0, 1, 4, 3, 4);
      applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 3, 4);
      #2;
      checkOutput("reset_entry3", rd_data[DW-1:0], 64'd0);
      checkOutput("reset_pending4", DW'(rd_pending[1]), 64'd0);

      $display("[TB] randomised soak");
      for (int n = 0; n < 600; n++) begin
         applyStimulus(($urandom_range(0, 63) == 0),
                       2'($urandom_range(0, 3)),
                       $urandom_range(0, 7), {$urandom, $urandom},
                       $urandom_range(0, 7), {$urandom, $urandom},
                       ($urandom_range(0, 1) == 1), $urandom_range(0, 7),
                       $urandom_range(0, 7), $urandom_range(0, NR-1));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
      $finish;
   end

endmodule
